alu: RTL and testbench

Combinational-core, output-registered 8-bit arithmetic/logic unit for the Z8-compatible CPU core. It executes the processor's one-operand and two-operand operations selected by a 5-bit mode code, and produces an 8-bit result plus the complete updated FLAGS byte. The processor writes that FLAGS byte back into its flags register (FC). It sits between the processor's operand registers (`aluA`, `aluB`, `aluMode`, `flags`) and its register-file/flags write-back path.

---
 rtl/alu.sv | 221 ++++++++++++++++++++++
 tb/tb_alu.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// 8-bit output-registered ALU for the Z8-compatible core: one-operand (mode[4]=0)
// and two-operand (mode[4]=1) ops, producing the result and the full new FLAGS byte.
// Optional decimal adjust for mode 0x04 is compiled in when ALU_DA_EN is defined.
module alu (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] mode,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] flags,
  output logic [7:0] out,
  output logic [7:0] outFlags
);

  localparam int FC = 7;
  localparam int FZ = 6;
  localparam int FS = 5;
  localparam int FV = 4;
  localparam int FD = 3;
  localparam int FH = 2;

  logic       w_cin;
  logic [8:0] w_add;
  logic [8:0] w_sub;
  logic       w_add_v;
  logic       w_sub_v;
  logic       w_add_h;
  logic       w_sub_h;
  logic [7:0] w_inc;
  logic [7:0] w_dec;
  logic [7:0] w_res;
  logic [7:0] w_nf;
  logic       w_zs_upd;
  logic       w_keep_a;
  logic [7:0] w_out;
  logic [7:0] r_out;
  logic [7:0] r_flags;

  // ADC/SBC are the odd codes of their pairs; CP (0x1A) is even and so borrows nothing
  assign w_cin   = mode[0] & flags[FC];
  assign w_add   = {1'b0, a} + {1'b0, b} + {8'd0, w_cin};
  assign w_sub   = {1'b0, a} - {1'b0, b} - {8'd0, w_cin};
  assign w_add_v = (a[7] == b[7]) & (w_add[7] != a[7]);
  assign w_sub_v = (a[7] != b[7]) & (w_sub[7] != a[7]);
  // carry/borrow into bit 4 recovered from the full-width result
  assign w_add_h = a[4] ^ b[4] ^ w_add[4];
  assign w_sub_h = a[4] ^ b[4] ^ w_sub[4];
  assign w_inc   = a + 8'd1;
  assign w_dec   = a - 8'd1;

`ifdef ALU_DA_EN
  logic       w_da_lo;
  logic       w_da_hi;
  logic [7:0] w_da_adj;
  logic [7:0] w_da_res;

  // after a subtraction only the recorded H/C borrows drive the correction
  assign w_da_lo  = flags[FH] | (~flags[FD] & (a[3:0] > 4'd9));
  assign w_da_hi  = flags[FC] | (~flags[FD] & (a > 8'h99));
  assign w_da_adj = {1'b0, w_da_hi, w_da_hi, 2'b00, w_da_lo, w_da_lo, 1'b0};
  assign w_da_res = flags[FD] ? (a - w_da_adj) : (a + w_da_adj);
`endif

  always_comb begin
    w_res    = a;
    w_nf     = flags;
    w_zs_upd = 1'b0;
    w_keep_a = 1'b0;
    case (mode)
      5'h00: begin
        w_res    = w_dec;
        w_nf[FV] = (a == 8'h80);
        w_zs_upd = 1'b1;
      end
      5'h01: begin
        w_res    = {a[6:0], flags[FC]};
        w_nf[FC] = a[7];
        w_nf[FV] = a[7] ^ a[6];
        w_zs_upd = 1'b1;
      end
      5'h02: begin
        w_res    = w_inc;
        w_nf[FV] = (a == 8'h7F);
        w_zs_upd = 1'b1;
      end
`ifdef ALU_DA_EN
      5'h04: begin
        w_res    = w_da_res;
        w_nf[FC] = w_da_hi;
        w_zs_upd = 1'b1;
      end
`endif
      5'h05: begin
        w_nf[FZ] = (a == 8'h00) & flags[FZ];
        w_nf[FS] = a[7];
        w_nf[FV] = 1'b0;
      end
      5'h06: begin
        w_res    = ~a;
        w_nf[FV] = 1'b0;
        w_zs_upd = 1'b1;
      end
      5'h08: begin
        w_res    = w_dec;
        w_nf[FZ] = (w_dec == 8'h00) & flags[FZ];
        w_nf[FS] = w_dec[7];
        w_nf[FV] = (a == 8'h80);
      end
      5'h09: begin
        w_res    = {a[6:0], a[7]};
        w_nf[FC] = a[7];
        w_nf[FV] = a[7] ^ a[6];
        w_zs_upd = 1'b1;
      end
      5'h0A: begin
        w_res    = w_inc;
        w_nf[FZ] = (w_inc == 8'h00) & flags[FZ];
        w_nf[FS] = w_inc[7];
        w_nf[FV] = (a == 8'h7F);
      end
      5'h0B: begin
        w_res = 8'h00;
      end
      5'h0C: begin
        w_res    = {flags[FC], a[7:1]};
        w_nf[FC] = a[0];
        w_nf[FV] = a[7] ^ flags[FC];
        w_zs_upd = 1'b1;
      end
      5'h0D: begin
        w_res    = {a[7], a[7:1]};
        w_nf[FC] = a[0];
        w_nf[FV] = 1'b0;
        w_zs_upd = 1'b1;
      end
      5'h0E: begin
        w_res    = {a[0], a[7:1]};
        w_nf[FC] = a[0];
        w_nf[FV] = a[7] ^ a[0];
        w_zs_upd = 1'b1;
      end
      5'h0F: begin
        w_res    = {a[3:0], a[7:4]};
        w_zs_upd = 1'b1;
      end
      5'h10, 5'h11: begin
        w_res    = w_add[7:0];
        w_nf[FC] = w_add[8];
        w_nf[FH] = w_add_h;
        w_nf[FV] = w_add_v;
        w_nf[FD] = 1'b0;
        w_zs_upd = 1'b1;
      end
      5'h12, 5'h13: begin
        w_res    = w_sub[7:0];
        w_nf[FC] = w_sub[8];
        w_nf[FH] = w_sub_h;
        w_nf[FV] = w_sub_v;
        w_nf[FD] = 1'b1;
        w_zs_upd = 1'b1;
      end
      5'h1A: begin
        w_res    = w_sub[7:0];
        w_nf[FC] = w_sub[8];
        w_nf[FV] = w_sub_v;
        w_zs_upd = 1'b1;
        w_keep_a = 1'b1;
      end
      5'h14: begin
        w_res    = a | b;
        w_nf[FV] = 1'b0;
        w_zs_upd = 1'b1;
      end
      5'h15: begin
        w_res    = a & b;
        w_nf[FV] = 1'b0;
        w_zs_upd = 1'b1;
      end
      5'h1B: begin
        w_res    = a ^ b;
        w_nf[FV] = 1'b0;
        w_zs_upd = 1'b1;
      end
      // test-under-mask: flags come from the masked value, the operand is returned untouched
      5'h16: begin
        w_res    = ~a & b;
        w_nf[FV] = 1'b0;
        w_zs_upd = 1'b1;
        w_keep_a = 1'b1;
      end
      5'h17: begin
        w_res    = a & b;
        w_nf[FV] = 1'b0;
        w_zs_upd = 1'b1;
        w_keep_a = 1'b1;
      end
      default: begin
        w_res = a;
      end
    endcase
    if (w_zs_upd) begin
      w_nf[FZ] = (w_res == 8'h00);
      w_nf[FS] = w_res[7];
    end
    w_out = w_keep_a ? a : w_res;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out   <= 8'h00;
      r_flags <= 8'h00;
    end else begin
      r_out   <= w_out;
      r_flags <= w_nf;
    end
  end

  assign out      = r_out;
  assign outFlags = r_flags;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: expected out/flags are queued when an op is driven
// and compared one cycle later against the registered outputs.
module tb_alu;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] mode;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] flags;
  logic [7:0] out;
  logic [7:0] outFlags;

  typedef struct {
    string      tag;
    logic [7:0] o;
    logic [7:0] f;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  alu dut (
    .clk(clk), .reset_n(reset_n), .mode(mode), .a(a), .b(b),
    .flags(flags), .out(out), .outFlags(outFlags)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
  endtask

  // independent reference: integer arithmetic and range tests for carry/overflow
  function automatic logic [15:0] ref_alu(input logic [4:0] m, input logic [7:0] ia,
                                          input logic [7:0] ib, input logic [7:0] f);
    logic [7:0] r;
    logic c, z, s, v, d, h, zs, keep;
    int sum, lo, sa, sb, sr, cin, adj;
    c = f[7]; z = f[6]; s = f[5]; v = f[4]; d = f[3]; h = f[2];
    r = ia; zs = 1'b0; keep = 1'b0;
    sa = ia[7] ? int'(ia) - 256 : int'(ia);
    sb = ib[7] ? int'(ib) - 256 : int'(ib);
    case (m)
      5'h00: begin r = ia - 8'd1; v = (ia == 8'h80); zs = 1'b1; end
      5'h01: begin r = {ia[6:0], c}; c = ia[7]; v = ia[7] ^ r[7]; zs = 1'b1; end
      5'h02: begin r = ia + 8'd1; v = (ia == 8'h7F); zs = 1'b1; end
`ifdef ALU_DA_EN
      5'h04: begin
        adj = 0;
        if (h || (!d && int'(ia[3:0]) > 9)) adj = adj + 6;
        if (c || (!d && int'(ia) > 153)) begin adj = adj + 96; c = 1'b1; end
        else c = 1'b0;
        sum = d ? int'(ia) - adj : int'(ia) + adj;
        r = sum[7:0]; zs = 1'b1;
      end
`endif
      5'h05: begin z = (ia == 8'h00) && z; s = ia[7]; v = 1'b0; end
      5'h06: begin r = ~ia; v = 1'b0; zs = 1'b1; end
      5'h08: begin r = ia - 8'd1; z = (r == 8'h00) && z; s = r[7]; v = (ia == 8'h80); end
      5'h09: begin r = {ia[6:0], ia[7]}; c = ia[7]; v = ia[7] ^ r[7]; zs = 1'b1; end
      5'h0A: begin r = ia + 8'd1; z = (r == 8'h00) && z; s = r[7]; v = (ia == 8'h7F); end
      5'h0B: r = 8'h00;
      5'h0C: begin r = {c, ia[7:1]}; c = ia[0]; v = ia[7] ^ r[7]; zs = 1'b1; end
      5'h0D: begin r = {ia[7], ia[7:1]}; c = ia[0]; v = 1'b0; zs = 1'b1; end
      5'h0E: begin r = {ia[0], ia[7:1]}; c = ia[0]; v = ia[7] ^ r[7]; zs = 1'b1; end
      5'h0F: begin r = {ia[3:0], ia[7:4]}; zs = 1'b1; end
      5'h10, 5'h11: begin
        cin = (m == 5'h11 && c) ? 1 : 0;
        sum = int'(ia) + int'(ib) + cin;
        lo  = int'(ia[3:0]) + int'(ib[3:0]) + cin;
        sr  = sa + sb + cin;
        r = sum[7:0]; c = (sum > 255); h = (lo > 15);
        v = (sr > 127) || (sr < -128); d = 1'b0; zs = 1'b1;
      end
      5'h12, 5'h13, 5'h1A: begin
        cin = (m == 5'h13 && c) ? 1 : 0;
        sum = int'(ia) - int'(ib) - cin;
        lo  = int'(ia[3:0]) - int'(ib[3:0]) - cin;
        sr  = sa - sb - cin;
        r = sum[7:0]; c = (sum < 0);
        v = (sr > 127) || (sr < -128); zs = 1'b1;
        if (m == 5'h1A) keep = 1'b1;
        else begin h = (lo < 0); d = 1'b1; end
      end
      5'h14: begin r = ia | ib; v = 1'b0; zs = 1'b1; end
      5'h15: begin r = ia & ib; v = 1'b0; zs = 1'b1; end
      5'h1B: begin r = ia ^ ib; v = 1'b0; zs = 1'b1; end
      5'h16: begin r = ~ia & ib; v = 1'b0; zs = 1'b1; keep = 1'b1; end
      5'h17: begin r = ia & ib; v = 1'b0; zs = 1'b1; keep = 1'b1; end
      default: r = ia;
    endcase
    if (zs) begin z = (r == 8'h00); s = r[7]; end
    return {(keep ? ia : r), c, z, s, v, d, h, f[1:0]};
  endfunction

  task automatic drive(input string tag, input logic [4:0] m, input logic [7:0] ia,
                       input logic [7:0] ib, input logic [7:0] ifl, input logic [15:0] ex);
    exp_t e;
    @(negedge clk);
    mode = m; a = ia; b = ib; flags = ifl;
    e.tag = tag; e.o = ex[15:8]; e.f = ex[7:0];
    sb_q.push_back(e);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (reset_n && sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        check_val({mon_e.tag, ".out"}, out, mon_e.o);
        check_val({mon_e.tag, ".flags"}, outFlags, mon_e.f);
      end
    end
  end

  initial begin
    logic [4:0] rm;
    logic [7:0] ra, rb, rf;
    reset_n = 1'b1; mode = 5'h0; a = 8'h0; b = 8'h0; flags = 8'h0;
    #2 reset_n = 1'b0;
    #1;
    check_val("rst.out", out, 8'h00);
    check_val("rst.flags", outFlags, 8'h00);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    drive("add",    5'h10, 8'h7F, 8'h01, 8'h00, 16'h8034);
    drive("sub",    5'h12, 8'h00, 8'h01, 8'h00, 16'hFFAC);
    drive("adc",    5'h11, 8'hFF, 8'h00, 8'h80, 16'h00C4);
    drive("sbc",    5'h13, 8'h10, 8'h01, 8'h80, 16'h0E0C);
    drive("da_add", 5'h10, 8'h15, 8'h27, 8'h00, 16'h3C00);
`ifdef ALU_DA_EN
    drive("da",     5'h04, 8'h3C, 8'h00, 8'h00, 16'h4200);
`else
    drive("da_ld",  5'h04, 8'h3C, 8'h00, 8'h00, 16'h3C00);
`endif
    drive("inc",    5'h02, 8'hFF, 8'h00, 8'h00, 16'h0040);
    drive("incw",   5'h0A, 8'h12, 8'h00, 8'h40, 16'h1300);
    drive("incw_ff",5'h0A, 8'hFF, 8'h00, 8'hC0, 16'h00C0);
    drive("rlc",    5'h01, 8'h81, 8'h00, 8'h00, 16'h0290);
    drive("cp",     5'h1A, 8'h05, 8'h05, 8'h0C, 16'h054C);
    drive("dec",    5'h00, 8'h80, 8'h00, 8'h00, 16'h7F10);
    drive("swap",   5'h0F, 8'h80, 8'h00, 8'h10, 16'h0810);
    drive("clr",    5'h0B, 8'h55, 8'h00, 8'hFF, 16'h00FF);
    drive("sra",    5'h0D, 8'h81, 8'h00, 8'h00, 16'hC0A0);
    drive("tcm",    5'h16, 8'hF0, 8'h0F, 8'h10, 16'hF000);
    drive("xor",    5'h1B, 8'h5A, 8'h5A, 8'h13, 16'h0043);
    drive("undef",  5'h1C, 8'hAA, 8'h33, 8'h5A, 16'hAA5A);

    // drop reset between edges while the last result is still held
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check_val("rst_mid.out", out, 8'h00);
    check_val("rst_mid.flags", outFlags, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 300; i++) begin
      rm = 5'($urandom_range(0, 31));
      ra = 8'($urandom);
      rb = 8'($urandom);
      rf = 8'($urandom);
      drive("rnd", rm, ra, rb, rf, ref_alu(rm, ra, rb, rf));
    end

    repeat (3) @(posedge clk);
    #2;
    check_val("drain", 8'(sb_q.size()), 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
